mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single-ported `memory` instance between the instruction fetch path (read-only) and the load/store unit (read/write).
- Issues at most one access per cycle and tracks the owner of each in-flight access through a fixed-latency pipeline.
- Routes each response back to its owner.
- Drops stale fetch responses on a branch redirect flush.
- Guarantees fetch forward progress with a starvation counter.

Parameters:
- ADDRESS_WIDTH, 64, width of all addresses.
- DATA_WIDTH, 64, width of the memory data bus and LSU data.
- MEM_LATENCY, 1, cycles from an address presented on mem_addr to valid mem_data_out; must be >= 1.
- STARVE_LIMIT, 4, consecutive denied fetch-request cycles before fetch is forced to win; must be >= 1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_req  in  1  fetch requests a read
- if_addr  in  ADDRESS_WIDTH  fetch address
- if_gnt  out  1  fetch request accepted this cycle
- if_flush  in  1  kill all in-flight fetch responses (branch redirect)
- if_resp_valid  out  1  fetch response valid
- if_resp_data  out  32  instruction, taken from mem_data_out[31:0]
- ls_req  in  1  LSU requests an access
- ls_write  in  1  1 = store, 0 = load
- ls_addr  in  ADDRESS_WIDTH  LSU address
- ls_wdata  in  DATA_WIDTH  store data
- ls_gnt  out  1  LSU request accepted this cycle
- ls_resp_valid  out  1  load data valid or store acknowledge
- ls_resp_data  out  DATA_WIDTH  load data; 0 for store acks
- mem_write  out  1  memory write enable
- mem_addr  out  ADDRESS_WIDTH  memory address
- mem_data_in  out  DATA_WIDTH  memory write data
- mem_data_out  in  DATA_WIDTH  memory read data, valid MEM_LATENCY cycles after its address

Behaviour:
- Handshake:
  - A requester holds req and its request fields stable until it sees gnt.
  - gnt is combinational in the same cycle as req.
  - At most one of if_gnt and ls_gnt is high in any cycle.
  - Responses have no backpressure.
- Arbitration (combinational, per cycle):
  - If if_flush is high, fetch is not eligible this cycle.
  - Else if starve_cnt == STARVE_LIMIT and if_req, fetch wins.
  - Else if ls_req, LSU wins.
  - Else if if_req, fetch wins.
  - Otherwise idle: mem_write=0, mem_addr holds its last value, mem_data_in=0.
- Memory drive:
  - The winner's address, write flag and wdata drive mem_* in the grant cycle.
  - mem_write is high only for a granted LSU store.
- Starvation counter:
  - starve_cnt (width clog2(STARVE_LIMIT+1)) increments, saturating at STARVE_LIMIT, when if_req && !if_gnt && !if_flush.
  - Clears to 0 on if_gnt or when if_req is low.
- Owner pipeline: shift register of MEM_LATENCY entries {valid, owner, is_write}, filled at the grant cycle and shifted every cycle.
- Response delivery:
  - When the tail entry is valid, the response goes to its owner exactly MEM_LATENCY cycles after the grant.
  - Fetch response: if_resp_valid=1, if_resp_data=mem_data_out[31:0].
  - LSU load: ls_resp_valid=1, ls_resp_data=mem_data_out.
  - LSU store: ls_resp_valid=1, ls_resp_data=0.
  - The response output of the non-owner stays low.
- Flush:
  - if_flush in cycle t clears valid on every fetch-owned entry in the pipeline, including any at the tail.
  - if_resp_valid is forced 0 in cycle t and for every earlier-granted fetch access.
  - LSU entries are unaffected.
  - A flush and an LSU grant in the same cycle are legal.
- Ordering: responses per requester return in grant order; there is no reordering.
- Reset:
  - All pipeline entries invalid, starve_cnt=0, mem_addr=0.
  - All gnt and resp_valid outputs are 0 in the reset cycle.
  - Accesses in flight at reset never produce responses, even if mem_data_out later changes.
- Simultaneous requests: both requesters high with the counter below limit gives the LSU the grant; the fetch is denied and the counter advances.

Decomposition:
- Shared package mem_arb_pkg:
  - typedef enum owner_t {OWNER_IF, OWNER_LS}.
  - struct inflight_t {valid, owner, is_write}.
- Sub-module arb_inflight_pipe:
  - MEM_LATENCY-deep shift register of inflight_t.
  - Has a flush input that clears fetch-owned entries.
  - Exposes the tail entry.
- The top-level module holds the arbitration logic, the starvation counter and the response routing.

Test Plan:
- MEM_LATENCY=1, only if_req with if_addr=0x10, memory holding 0x00000013 there → if_gnt in cycle 0; mem_addr=0x10 in cycle 0; if_resp_valid=1 with data 0x13 in cycle 1.
- ls_req store to addr 0x20 with wdata 0xDEAD, followed by a load of 0x20 → cycle 0: mem_write=1, ls_gnt=1. Cycle 1: ls_resp_valid=1, data 0. Cycle 2: load response 0xDEAD.
- if_req and ls_req both held high continuously, STARVE_LIMIT=4 → ls_gnt in cycles 0-3, if_gnt in cycle 4, then ls_gnt again; the pattern repeats every 5 cycles.
- MEM_LATENCY=3, fetch granted in cycles 0 and 1, if_flush pulsed in cycle 2 → no if_resp_valid in cycles 3 or 4; an LSU load granted in cycle 2 still responds in cycle 5.
- Same-cycle if_flush with if_req and no ls_req → if_gnt=0, no memory access, starve_cnt unchanged; fetch is granted in the next cycle if the flush drops.
- rst asserted for 1 cycle while 2 accesses are in flight (MEM_LATENCY=3) → no resp_valid in the following 3 cycles; starve_cnt=0; new requests are granted normally afterward.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: access owner and the in-flight
// bookkeeping entry carried alongside each memory access.
package mem_arb_pkg;

    localparam int IF_DATA_WIDTH = 32;

    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_LS = 1'b1
    } owner_t;

    typedef struct packed {
        logic   valid;
        owner_t owner;
        logic   is_write;
    } inflight_t;

    localparam inflight_t INFLIGHT_IDLE = '{valid: 1'b0, owner: OWNER_IF, is_write: 1'b0};

    // A flush kills fetch-owned entries; LSU entries pass through untouched.
    function automatic inflight_t kill_fetch(inflight_t e, logic flush);
        inflight_t r;
        r = e;
        if (flush && e.owner == OWNER_IF)
            r.valid = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/arb_inflight_pipe.sv
// Fixed-depth shift register tracking the owner of every in-flight access;
// the tail entry lines up with the memory read data for that access.
module arb_inflight_pipe
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      flush,
    input  inflight_t push,
    output inflight_t tail
);

    inflight_t stage [DEPTH];

    always_ff @(posedge clk) begin
        // NOTE: this is a handful of flops, not a RAM, so every entry is reset to invalid.
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                stage[i] <= INFLIGHT_IDLE;
        end else begin
            // NOTE: non-blocking assignments let every stage shift from its old neighbour.
            stage[0] <= kill_fetch(push, flush);
            for (int i = 1; i < DEPTH; i++)
                stage[i] <= kill_fetch(stage[i-1], flush);
        end
    end

    assign tail = stage[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and the LSU:
// per-cycle arbitration with a fetch starvation guard, and response routing.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 64,
    parameter int DATA_WIDTH    = 64,
    parameter int MEM_LATENCY   = 1,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     if_req,
    input  logic [ADDRESS_WIDTH-1:0] if_addr,
    output logic                     if_gnt,
    input  logic                     if_flush,
    output logic                     if_resp_valid,
    output logic [IF_DATA_WIDTH-1:0] if_resp_data,
    input  logic                     ls_req,
    input  logic                     ls_write,
    input  logic [ADDRESS_WIDTH-1:0] ls_addr,
    input  logic [DATA_WIDTH-1:0]    ls_wdata,
    output logic                     ls_gnt,
    output logic                     ls_resp_valid,
    output logic [DATA_WIDTH-1:0]    ls_resp_data,
    output logic                     mem_write,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_data_in,
    input  logic [DATA_WIDTH-1:0]    mem_data_out
);

    localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0]         starve_cnt;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic                     if_win;
    logic                     ls_win;
    inflight_t                push;
    inflight_t                tail;

    // Fetch is ineligible during a flush; a starved fetch beats the LSU.
    always_comb begin
        // NOTE: defaults first so no path through the block infers a latch.
        if_win = 1'b0;
        ls_win = 1'b0;
        if (!rst) begin
            if (!if_flush && if_req && starve_cnt == CNT_MAX)
                if_win = 1'b1;
            else if (ls_req)
                ls_win = 1'b1;
            else if (!if_flush && if_req)
                if_win = 1'b1;
        end
    end

    assign if_gnt = if_win;
    assign ls_gnt = ls_win;

    always_comb begin
        mem_write   = 1'b0;
        mem_addr    = addr_q;
        mem_data_in = '0;
        if (ls_win) begin
            mem_write   = ls_write;
            mem_addr    = ls_addr;
            mem_data_in = ls_wdata;
        end else if (if_win) begin
            mem_addr = if_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
            addr_q     <= '0;
        end else begin
            if (if_win || ls_win)
                addr_q <= mem_addr;
            // A flushed cycle neither advances nor clears the count.
            if (if_win || !if_req)
                starve_cnt <= '0;
            else if (!if_flush && starve_cnt != CNT_MAX)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

    always_comb begin
        push          = INFLIGHT_IDLE;
        push.valid    = if_win || ls_win;
        push.owner    = ls_win ? OWNER_LS : OWNER_IF;
        push.is_write = ls_win && ls_write;
    end

    arb_inflight_pipe #(
        .DEPTH (MEM_LATENCY)
    ) u_pipe (
        .clk   (clk),
        .rst   (rst),
        .flush (if_flush),
        .push  (push),
        .tail  (tail)
    );

    // The tail entry is consumed this cycle, so a same-cycle flush masks it here.
    always_comb begin
        if_resp_valid = 1'b0;
        if_resp_data  = '0;
        ls_resp_valid = 1'b0;
        ls_resp_data  = '0;
        if (!rst && tail.valid) begin
            if (tail.owner == OWNER_IF) begin
                if_resp_valid = !if_flush;
                if_resp_data  = mem_data_out[IF_DATA_WIDTH-1:0];
            end else begin
                ls_resp_valid = 1'b1;
                ls_resp_data  = tail.is_write ? '0 : mem_data_out;
            end
        end
    end

endmodule
